// File: rtl/player_race_counter_if.sv
// Player-side race signals: game enable and raw keys in, score/box/status out.
// The design owns the slave modport; whatever drives the keys uses master.
interface player_race_counter_if;
  logic       enable;
  logic       left_n;
  logic       right_n;
  logic       box_out;
  logic [3:0] score_one;
  logic [3:0] score_two;
  logic       correct_pulse;
  logic       wrong_pulse;
  logic       stalled;
  logic       finished;

  modport slave (
    input  enable, left_n, right_n,
    output box_out, score_one, score_two, correct_pulse, wrong_pulse,
           stalled, finished
  );

  modport master (
    output enable, left_n, right_n,
    input  box_out, score_one, score_two, correct_pulse, wrong_pulse,
           stalled, finished
  );
endinterface

// File: rtl/player_race_counter.sv
// Player race counter: synchronises KEY[3]/KEY[2], checks each press against the
// course, counts boxes remaining in BCD and locks the player out after a wrong key.
module player_race_counter #(
  parameter logic [32:0] COURSE         = 33'b0_1101_0001_0101_1101_1001_0110_1000_1001,
  parameter int          PENALTY_CYCLES = 25_000_000
) (
  input  logic                    clock,
  input  logic                    resetn,
  player_race_counter_if.slave    bus
);

  localparam int PEN_W = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
  localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(PENALTY_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_STALL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Key pipelines, index 0 = left, index 1 = right, all active-high.
  logic [1:0]       key_meta_q;
  logic [1:0]       key_sync_q;
  logic [1:0]       key_prev_q;
  logic [1:0]       press;

  state_t           state_q,   state_d;
  logic [32:0]      course_q,  course_d;
  logic [3:0]       ones_q,    ones_d;
  logic [3:0]       tens_q,    tens_d;
  logic [PEN_W-1:0] pen_q,     pen_d;
  logic             correct_q, correct_d;
  logic             wrong_q,   wrong_d;

  logic             press_l;
  logic             press_r;
  logic             good_move;

  assign press     = key_sync_q & ~key_prev_q;
  assign press_l   = press[0];
  assign press_r   = press[1];
  assign good_move = (press_l ^ press_r) && (press_r == course_q[0]);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_meta_q <= 2'b00;
      key_sync_q <= 2'b00;
      key_prev_q <= 2'b00;
      state_q    <= S_PLAY;
      course_q   <= COURSE;
      ones_q     <= 4'd2;
      tens_q     <= 4'd3;
      pen_q      <= '0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
    end else begin
      key_meta_q <= ~{bus.right_n, bus.left_n};
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      state_q    <= state_d;
      course_q   <= course_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      pen_q      <= pen_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    course_d  = course_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    pen_d     = pen_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;

    case (state_q)
      S_PLAY: begin
        if (bus.enable && (press_l || press_r)) begin
          if (good_move) begin
            correct_d = 1'b1;
            course_d  = {1'b0, course_q[32:1]};
            if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
            // Taking the last box (01 -> 00) ends the race.
            if (tens_q == 4'd0 && ones_q == 4'd1) begin
              state_d = S_DONE;
            end
          end else begin
            wrong_d = 1'b1;
            pen_d   = PEN_LOAD;
            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (bus.enable) begin
          if (pen_q == '0) begin
            state_d = S_PLAY;
          end else begin
            pen_d = pen_q - PEN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_PLAY;
      end
    endcase
  end

  assign bus.box_out       = course_q[0];
  assign bus.score_one     = ones_q;
  assign bus.score_two     = tens_q;
  assign bus.correct_pulse = correct_q;
  assign bus.wrong_pulse   = wrong_q;
  assign bus.stalled       = (state_q == S_STALL);
  assign bus.finished      = (state_q == S_DONE);

endmodule

// File: tb/tb_player_race_counter.sv
// Bench for player_race_counter: directed steps plus a random full-course run,
// every cycle compared against a boxes-remaining / lockout-countdown model.
module tb_player_race_counter;
  localparam int          PEN       = 4;
  localparam logic [32:0] COURSE_TB = 33'b0_1101_0001_0101_1101_1001_0110_1000_1001;

  logic clock;
  logic resetn;
  player_race_counter_if bus ();

  player_race_counter #(
    .COURSE         (COURSE_TB),
    .PENALTY_CYCLES (PEN)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: boxes left, boxes taken, lockout cycles still owed.
  logic [32:0] course_v;
  int  m_rem;
  int  m_idx;
  int  m_stall;
  bit  m_done;
  bit  m_cp;
  bit  m_wp;

  function automatic bit exp_box();
    return (m_idx <= 32) ? course_v[m_idx] : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("box_out",       {7'd0, bus.box_out},       {7'd0, exp_box()});
    chk("score_one",     {4'd0, bus.score_one},     8'(m_rem % 10));
    chk("score_two",     {4'd0, bus.score_two},     8'(m_rem / 10));
    chk("correct_pulse", {7'd0, bus.correct_pulse}, {7'd0, m_cp});
    chk("wrong_pulse",   {7'd0, bus.wrong_pulse},   {7'd0, m_wp});
    chk("stalled",       {7'd0, bus.stalled},       {7'd0, (m_stall > 0)});
    chk("finished",      {7'd0, bus.finished},      {7'd0, m_done});
  endtask

  // One clock edge; pl/pr mark the edge at which a press started by the bench is decoded.
  task automatic tick(input bit pl, input bit pr);
    @(posedge clock);
    m_cp = 1'b0;
    m_wp = 1'b0;
    if (!resetn) begin
      m_rem   = 32;
      m_idx   = 0;
      m_stall = 0;
      m_done  = 1'b0;
    end else if (bus.enable && !m_done) begin
      if (m_stall > 0) begin
        m_stall--;
      end else if (pl || pr) begin
        if ((pl != pr) && (pr == exp_box())) begin
          m_cp = 1'b1;
          m_rem--;
          m_idx++;
          if (m_rem == 0) m_done = 1'b1;
        end else begin
          m_wp    = 1'b1;
          m_stall = PEN;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    resetn = 1'b1;
  endtask

  task automatic press(input bit l, input bit r, input int hold, input int gap);
    if (l) bus.left_n = 1'b0;
    if (r) bus.right_n = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(l, r);
    for (int i = 3; i < hold; i++) tick(1'b0, 1'b0);
    bus.left_n  = 1'b1;
    bus.right_n = 1'b1;
    for (int i = 0; i < gap; i++) tick(1'b0, 1'b0);
  endtask

  task automatic press_move(input bit correct, input int hold, input int gap);
    bit want_r;
    want_r = correct ? exp_box() : ~exp_box();
    press(~want_r, want_r, hold, gap);
  endtask

  initial begin
    int n;
    course_v    = COURSE_TB;
    m_rem       = 32;
    m_idx       = 0;
    m_stall     = 0;
    m_done      = 1'b0;
    m_cp        = 1'b0;
    m_wp        = 1'b0;
    resetn      = 1'b0;
    bus.enable  = 1'b0;
    bus.left_n  = 1'b1;
    bus.right_n = 1'b1;

    // Reset state.
    do_reset();
    tick(1'b0, 1'b0);

    // Keys held through reset and through enable rising: no press.
    bus.left_n  = 1'b0;
    bus.right_n = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    bus.left_n  = 1'b1;
    bus.right_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

    // Correct sequence right, left, left, right.
    press(1'b0, 1'b1, 2, 5);
    press(1'b1, 1'b0, 2, 5);
    press(1'b1, 1'b0, 2, 5);
    press(1'b0, 1'b1, 2, 5);

    // Wrong key, press during stall discarded, press after stall accepted.
    press_move(1'b0, 2, 0);
    press_move(1'b1, 2, 8);
    press_move(1'b1, 2, 6);

    // Both keys together, then one long hold.
    press(1'b1, 1'b1, 2, 8);
    press_move(1'b1, 100, 6);

    // enable low freezes the lockout.
    press_move(1'b0, 1, 0);
    bus.enable = 1'b0;
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
    bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);

    // Reset in the middle of a stall.
    press_move(1'b0, 1, 0);
    tick(1'b0, 1'b0);
    do_reset();
    tick(1'b0, 1'b0);

    // Random run over the full course.
    n = 0;
    while (!m_done && n < 300) begin
      press_move(($urandom % 4) != 0, int'($urandom_range(1, 6)), int'($urandom_range(4, 9)));
      n++;
    end
    chk("course_completed", {7'd0, bus.finished}, 8'd1);

    // Presses after DONE are ignored.
    press(1'b0, 1'b1, 2, 5);
    press(1'b1, 1'b0, 2, 5);
    press(1'b1, 1'b1, 2, 5);

    // Reset out of DONE, then play resumes.
    do_reset();
    tick(1'b0, 1'b0);
    press_move(1'b1, 2, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
